// File: rtl/sum_of_n_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sum_of_n_pkg : shared FSM state type and default widths for sum_of_n   |
// | Revision     : 1.0                                                    |
// +----------------------------------------------------------------------+
package sum_of_n_pkg;

  localparam int NW_DEF = 4;
  localparam int SW_DEF = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/sum_of_n_num_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sum_of_n_num_if : request/result bundle of the sum_of_n_num helper     |
// | Revision        : 1.0                                                 |
// +----------------------------------------------------------------------+
interface sum_of_n_num_if #(
  parameter int NW = 4,
  parameter int SW = 5
);

  logic          start;
  logic [NW-1:0] N;
  logic [SW-1:0] S;
  logic          busy;
  logic          done;
  logic          ovf;

  modport master (output start, N, input S, busy, done, ovf);
  modport slave  (input start, N, output S, busy, done, ovf);

endinterface
`default_nettype wire

// File: rtl/sum_of_n_num.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sum_of_n_num : iterative 1+2+..+N accumulator, one term per clock      |
// | Optional macro SUMN_ASSERT_EN compiles in simulation-only checks.      |
// | Revision     : 1.0                                                    |
// +----------------------------------------------------------------------+
module sum_of_n_num
  import sum_of_n_pkg::*;
#(
  parameter int NW = NW_DEF,
  parameter int SW = SW_DEF
) (
  input  wire logic        clk,
  input  wire logic        rst,
  sum_of_n_num_if.slave    bus
);

  // Adder wide enough for both operands plus carry, whatever NW/SW are.
  localparam int AW = ((NW > SW) ? NW : SW) + 1;

  state_e        state_q, state_d;
  logic [SW-1:0] acc_q,   acc_d;
  logic [NW-1:0] cnt_q,   cnt_d;
  logic          ovf_q,   ovf_d;

  logic [AW-1:0] add_w;
  logic          carry_w;

  assign add_w   = AW'(acc_q) + AW'(cnt_q);
  assign carry_w = |add_w[AW-1:SW];

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = bus.N;
          state_d = (bus.N == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d = add_w[SW-1:0];
        ovf_d = ovf_q | carry_w;
        cnt_d = cnt_q - NW'(1);
        if (cnt_q == NW'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.S    = acc_q;
  assign bus.ovf  = ovf_q;
  assign bus.busy = (state_q == ST_RUN);
  assign bus.done = (state_q == ST_DONE);

`ifdef SUMN_ASSERT_EN
  // cnt_q counts down, so the operand is kept separately for the result check.
  logic [NW-1:0] n_cap_q;
  logic          done_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      n_cap_q     <= '0;
      done_prev_q <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && bus.start) begin
        n_cap_q <= bus.N;
      end
      done_prev_q <= bus.done;
    end
  end

  always_ff @(posedge clk) begin
    longint unsigned true_sum;
    true_sum = (longint'(n_cap_q) * (longint'(n_cap_q) + 1)) / 2;
    if (!rst) begin
      if (bus.done) begin
        assert (bus.S == SW'(true_sum))
          else $error("sum_of_n_num: S=%0d wrong for N=%0d", bus.S, n_cap_q);
        assert (bus.ovf == (true_sum > ((longint'(1) << SW) - 1)))
          else $error("sum_of_n_num: ovf=%0b wrong for N=%0d", bus.ovf, n_cap_q);
      end
      assert (!(bus.done && done_prev_q))
        else $error("sum_of_n_num: done high on consecutive cycles");
      assert (!(bus.busy && bus.done))
        else $error("sum_of_n_num: busy and done both high");
    end
  end
`else
`endif

endmodule
`default_nettype wire

// File: tb/tb_sum_of_n_num.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sum_of_n_num : directed self-checking bench for sum_of_n_num        |
// | Revision        : 1.0                                                 |
// +----------------------------------------------------------------------+
module tb_sum_of_n_num;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  sum_of_n_num_if #(.NW(4), .SW(5)) bus ();

  sum_of_n_num #(.NW(4), .SW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Caller is 1 time unit past an edge with the DUT in IDLE.
  task automatic wait_done(input string tag, input int exp_lat, input int exp_busy,
                           input int exp_s, input int exp_ovf);
    int lat;
    int busy_cnt;
    lat      = 1;
    busy_cnt = 0;
    while (bus.done !== 1'b1 && lat < 40) begin
      if (bus.busy === 1'b1) busy_cnt++;
      step();
      lat++;
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_busy_cycles"}, busy_cnt, exp_busy);
    chk({tag, "_S"}, bus.S, exp_s);
    chk({tag, "_ovf"}, bus.ovf, exp_ovf);
    chk({tag, "_busy_at_done"}, bus.busy, 0);
    step();
    chk({tag, "_done_one_cycle"}, bus.done, 0);
    chk({tag, "_S_held"}, bus.S, exp_s);
    chk({tag, "_ovf_held"}, bus.ovf, exp_ovf);
  endtask

  task automatic do_op(input string tag, input int n, input int exp_s, input int exp_ovf);
    bus.start = 1'b1;
    bus.N     = 4'(n);
    step();
    bus.start = 1'b0;
    bus.N     = ~4'(n);
    wait_done(tag, n + 1, n, exp_s, exp_ovf);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.N     = 4'd5;
    step();
    step();
    chk("rst_S", bus.S, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_ovf", bus.ovf, 0);
    rst       = 1'b0;
    bus.start = 1'b0;
    step();
    chk("post_rst_busy", bus.busy, 0);
    chk("post_rst_done", bus.done, 0);

    do_op("n4", 4, 10, 0);
    do_op("n8", 8, 4, 1);
    do_op("n15", 15, 24, 1);
    do_op("n0", 0, 0, 0);

    // A start raised while running must not disturb the N=7 computation.
    bus.start = 1'b1;
    bus.N     = 4'd7;
    step();
    bus.start = 1'b0;
    step();
    step();
    bus.start = 1'b1;
    bus.N     = 4'd3;
    step();
    bus.start = 1'b0;
    chk("midrun_busy", bus.busy, 1);
    wait_done("n7_ignore", 8 - 3, 7 - 3, 28, 0);
    do_op("n3_b2b", 3, 6, 0);

    // Abort N=10 by reset in cycle 4 after accept.
    bus.start = 1'b1;
    bus.N     = 4'd10;
    step();
    bus.start = 1'b0;
    step();
    step();
    step();
    chk("abort_S_cycle4", bus.S, 27);
    chk("abort_busy_cycle4", bus.busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_S", bus.S, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_ovf", bus.ovf, 0);
    for (int i = 0; i < 12; i++) begin
      step();
      chk("abort_no_done", bus.done, 0);
    end
    do_op("n5_after_abort", 5, 15, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sum_of_n_num.md
Name: sum_of_n_num

Overview:
- Sequential iterative accumulator: on a start request, computes S = 1 + 2 + … + N for an unsigned N.
- Adds one term per clock, then raises a one-cycle done pulse.
- Result is held, truncated to the output width, with an overflow flag.
- Used as a small arithmetic helper in a controller datapath; the single clock domain drives all state.

Parameters:
- NW, 4, width of operand N.
- SW, 5, width of result S; result is modulo 2^SW.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- start  input  1  request a computation; sampled only in IDLE
- N  input  NW  operand, captured when start is accepted
- S  output  SW  sum of 1..N modulo 2^SW; held until the next accepted start
- busy  output  1  high while a computation is in progress (RUN state)
- done  output  1  one-cycle pulse when S is valid
- ovf  output  1  high if the true sum exceeded 2^SW-1; valid with done; held

Behaviour:
- Reset: rst high at a clk edge puts the FSM in IDLE and forces S=0, busy=0, done=0, ovf=0, and internal counter=0. Reset applies in any state and aborts a computation in progress.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On start=1: acc<=0, ovf<=0, cnt<=N.
  - If N==0, next state is DONE; otherwise next state is RUN.
  - start=0: stay in IDLE.
- RUN:
  - Each cycle: acc<=acc+cnt, truncated to SW bits; ovf<=ovf | carry-out; cnt<=cnt-1.
  - When cnt==1 (last term), next state is DONE.
  - start is ignored.
- DONE: done=1 for exactly one cycle; next state is IDLE. start is ignored in this cycle.
- S is driven directly from acc.
- busy = (state==RUN).
- Latency: done is high in the (N+1)th cycle after the start-accept edge. N=0 gives 1 cycle; N=15 gives 16 cycles.
- Back-to-back operation: start asserted in the cycle after done (IDLE) is accepted. Minimum issue interval is N+2 cycles.
- Arithmetic: unsigned throughout; the counter is NW bits wide; the accumulator is SW bits, keeping the modulo result.
- N may change freely after capture without affecting the computation in progress.

Optional Feature:
- Macro: SUMN_ASSERT_EN.
- When defined, simulation-only checks are compiled in:
  - On done, S == (N_cap*(N_cap+1)/2) mod 2^SW.
  - ovf equals (true sum > 2^SW-1).
  - done never asserts on two consecutive cycles.
  - busy and done are never both high.
  - Any violation is reported as an error.
- When undefined, no check logic is present; synthesized behaviour is identical either way.

Decomposition:
- Shared package sum_of_n_pkg:
  - FSM state typedef (IDLE/RUN/DONE, 2-bit encoding).
  - Default width constants NW_DEF=4 and SW_DEF=5.
- No sub-module is needed; the accumulator and FSM fit naturally in one module.
- A standalone combinational reference model (sum_of_n_ref) for the bench is natural.

Test Plan:
- rst held 2 cycles, then released -> S=0, busy=0, done=0, ovf=0; start during rst has no effect.
- N=4, start pulse -> busy for 4 cycles, done in 5th cycle, S=10, ovf=0.
- N=8 -> S=4 (36 mod 32), ovf=1. N=15 -> S=24 (120 mod 32), ovf=1, done after 16 cycles.
- N=0 -> done 1 cycle after accept, S=0, ovf=0, busy never high.
- Start N=7, then pulse start with N=3 mid-RUN -> second start ignored, S=28; start N=3 the cycle after done -> S=6.
- Start N=10, assert rst at cycle 4 -> IDLE, S=0, no done pulse; a new start N=5 afterwards -> S=15.
